// File: rtl/serial_full_adder_pkg.sv
// serial_full_adder_pkg: FSM states and full-adder truth tables
package serial_full_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [7:0] FA_SUM = 8'b1001_0110;
  localparam logic [7:0] FA_CARRY = 8'b1110_1000;
endpackage

// File: rtl/serial_full_adder_mux.sv
// full_adder_mux: 1-bit full adder from two 8:1 muxes indexed by {a,b,cin}
module full_adder_mux
  import serial_full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic [2:0] sel;
  assign sel = {a, b, cin};
  assign s = FA_SUM[sel];
  assign co = FA_CARRY[sel];
endmodule

// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial LSB-first adder with start/busy/done handshake
module serial_full_adder
  import serial_full_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_co, last;
  full_adder_mux u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(fa_s), .co(fa_co));
  assign last = cnt == CW'(WIDTH - 1);
  assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_comb begin
    state_n = (state == IDLE) ? (start ? SHIFT : IDLE) :
              (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  end
  // the final bit is folded straight into sum so partial results never reach the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        carry <= cin;
        cnt <= '0;
      end else if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        s_sh <= s_nxt;
        carry <= fa_co;
        cnt <= cnt + CW'(1);
        if (last) begin
          sum <= s_nxt;
          cout <= fa_co;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder: randomized scoreboard bench against an arithmetic reference
module tb_serial_full_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [W-1:0] sum;
  logic [W:0] q[$];
  logic [W:0] held = '0;
  int wait_n = 0, n_ops = 0, rst_gen = 0, rst_seen = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit armed = 1'b0;

  serial_full_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [W:0] act, logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference: an accepted start occupies the block for W+2 cycles; result is plain a+b+cin
  always @(posedge clk) begin
    if (rst) begin
      wait_n = 0;
      q.delete();
      rst_gen++;
    end else if (wait_n > 0) begin
      wait_n--;
    end else if (start) begin
      q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
      wait_n = W + 1;
      n_ops++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (rst_seen != rst_gen) begin
        rst_seen = rst_gen;
        held = '0;
      end
      chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, wait_n >= 2});
      chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, wait_n == 1});
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          held = q.pop_front();
        end
      end
      chk("result", {cout, sum}, held);
    end
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    int target;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    op(8'h0F, 8'h01, 1'b0);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hFF, 8'hFF, 1'b1);
    op(8'h00, 8'h00, 1'b0);
    start = 1'b1;
    repeat (3 * (W + 2)) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(negedge clk);
    op(8'h80, 8'h80, 1'b1);
    target = n_ops + 1000;
    while (n_ops < target && cyc < 40000) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk("ops_completed", (n_ops >= target) ? 9'd1 : 9'd0, 9'd1);
    chk("queue_empty", (W + 1)'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
